// File: rtl/w_mem_stream.sv
// Writable weight memory that streams all NUM_WEIGHT words in address order to a neuron MAC.
// Latency: start accepted at edge t, busy from t+1, first word valid from t+2; one word per cycle while ready.
// Backpressure: out_ready low holds wout/wout_last stable with no drop; writes while not IDLE are rejected.
module w_mem_stream #(
  parameter int NUM_WEIGHT = 10,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] wadd,
  input  logic [DATA_WIDTH-1:0] win,
  output logic                  wr_drop,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] wout,
  output logic                  wout_last
);

  // rd_ptr must be able to hold NUM_WEIGHT itself, where it saturates
  localparam int PTR_W = $clog2(NUM_WEIGHT + 1);
  localparam logic [PTR_W-1:0] END_PTR  = PTR_W'(NUM_WEIGHT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_WEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] mem [NUM_WEIGHT];
  logic                  wr_ok;
  logic                  rd_en;

  assign wr_ok = wen && (state == IDLE) && (PTR_W'(wadd) < END_PTR);
  assign rd_en = (state == STREAM) && (rd_ptr < END_PTR) && (!out_valid || out_ready);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if ((rd_ptr == END_PTR) && out_valid && out_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Weight storage is deliberately left out of reset so contents survive a mid-stream reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wadd] <= win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wout      <= '0;
      wout_last <= 1'b0;
      out_valid <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      wr_drop <= wen && !wr_ok;
      if ((state == IDLE) && start) rd_ptr <= '0;
      else if (rd_en)               rd_ptr <= rd_ptr + PTR_W'(1);
      if (rd_en) begin
        wout      <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        wout_last <= (rd_ptr == LAST_PTR);
      end
      if (rd_en)          out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w_mem_stream.sv
// Directed bench for w_mem_stream: load, stream with and without stalls, rejected writes,
// ignored restart, mid-stream reset and write-with-start.
module tb_w_mem_stream;

  localparam int NW = 10;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wen;
  logic [AW-1:0] wadd;
  logic [DW-1:0] win;
  logic          wr_drop;
  logic          start;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] wout;
  logic          wout_last;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mdl [NW];

  w_mem_stream #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .wadd      (wadd),
    .win       (win),
    .wr_drop   (wr_drop),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wout      (wout),
    .wout_last (wout_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data, input logic exp_drop);
    wen  = 1'b1;
    wadd = AW'(addr);
    win  = data;
    step();
    wen = 1'b0;
    chk("wr_drop", wr_drop, exp_drop);
    if (!exp_drop) mdl[addr] = data;
  endtask

  // Collect one full stream, checking order, last flag, stall stability and a single done pulse.
  task automatic stream(input string tag, input int mode, input bit do_start, input int restart_idx);
    int idx = 0;
    int dn = 0;
    int post = 0;
    bit prev_stall = 1'b0;
    logic [DW:0] prev = '0;
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1'b1);
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (prev_stall) chk({tag, "_hold"}, {out_valid, wout_last, wout}, {1'b1, prev});
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      start = (restart_idx >= 0) && (idx == restart_idx);
      if (out_valid && out_ready) begin
        if (idx < NW) begin
          chk({tag, "_wout"}, wout, mdl[idx]);
          chk({tag, "_last"}, wout_last, (idx == NW - 1));
        end
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {wout_last, wout};
      if (done) begin
        dn++;
        chk({tag, "_done_busy"}, busy, 1'b0);
      end
      if (dn > 0) post++;
      if (post > 4) break;
      step();
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_nwords"}, idx, NW);
    chk({tag, "_ndone"}, dn, 1);
    chk({tag, "_end_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    wen = 1'b0;
    wadd = '0;
    win = '0;
    start = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_drop", wr_drop, 1'b0);
    chk("rst_wout", wout, 16'h0000);
    chk("rst_last", wout_last, 1'b0);
    rst_n = 1'b1;
    step();

    // 1: load and stream back-to-back, exact cycle timing
    for (int i = 0; i < NW; i++) wr(i, 16'h1000 + DW'(i), 1'b0);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_valid_early", out_valid, 1'b0);
    step();
    for (int i = 0; i < NW; i++) begin
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_wout", wout, 16'h1000 + DW'(i));
      chk("t1_last", wout_last, (i == NW - 1));
      step();
    end
    chk("t1_done", done, 1'b1);
    chk("t1_done_busy", busy, 1'b0);
    chk("t1_valid_after", out_valid, 1'b0);
    step();
    chk("t1_done_pulse", done, 1'b0);
    out_ready = 1'b0;

    // 2: ready pattern 1,0,0,...
    stream("t2", 1, 1'b1, -1);

    // 3: write during STREAM and out-of-range write are both dropped
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    wr(3, 16'hDEAD, 1'b1);
    step();
    chk("t3_drop_pulse", wr_drop, 1'b0);
    stream("t3a", 0, 1'b0, -1);
    wr(12, 16'h5555, 1'b1);
    stream("t3b", 0, 1'b1, -1);
    chk("t3_mem3", mdl[3], 16'h1003);

    // 4: start again at word 5 is ignored
    stream("t4", 0, 1'b1, 5);

    // 5: reset after word 4 accepted
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (5) step();
    chk("t5_pre_wout", wout, 16'h1005);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_wout", wout, 16'h0000);
    chk("t5_rst_last", wout_last, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    out_ready = 1'b0;
    #20;
    rst_n = 1'b1;
    step();
    stream("t5", 0, 1'b1, -1);

    // 6: write word 0 in the same cycle as start
    out_ready = 1'b0;
    wen = 1'b1;
    wadd = '0;
    win = 16'hBEEF;
    start = 1'b1;
    step();
    wen = 1'b0;
    start = 1'b0;
    mdl[0] = 16'hBEEF;
    chk("t6_wr_drop", wr_drop, 1'b0);
    chk("t6_busy", busy, 1'b1);
    step();
    chk("t6_valid", out_valid, 1'b1);
    chk("t6_first", wout, 16'hBEEF);
    stream("t6", 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
